mul_iter: RTL and testbench

Parametrised, iterative, handshaked integer multiplier. It produces the full 2*WIDTH-bit product of two WIDTH-bit operands, and each operand can be independently signed or unsigned (covers MUL/MULH/MULHSU/MULHU). The block consumes RADIX_BITS multiplier bits per cycle, trading the large combinational adder tree for a small shift-add datapath. It sits in the execute stage behind a valid/ready interface and supports abort on pipeline flush.

---
 rtl/mul_iter_if.sv | 27 ++
 rtl/mul_iter.sv | 165 ++++++++++++++++
 tb/tb_mul_iter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_iter_if.sv
// Request/response bundle for mul_iter.
// Ports (master side drives): in_valid, op1, op2, mode, abort, out_ready.
// Ports (slave side drives):  in_ready, out_valid, res, busy.
interface mul_iter_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic [1:0]         mode;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] res;
    logic               busy;

    modport master (
        output in_valid, op1, op2, mode, abort, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, op1, op2, mode, abort, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier producing the full 2*WIDTH-bit product.
// Each operand is independently signed/unsigned (mode bit0: op1, bit1: op2).
// RADIX_BITS multiplier bits are retired per cycle (N = WIDTH/RADIX_BITS).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mul_iter_if.slave: in_valid/in_ready/op1/op2/mode request,
//          out_valid/out_ready/res response, abort, busy status
module mul_iter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 2
) (
    input  logic   clk,
    input  logic   rst,
    mul_iter_if.slave bus
);
    localparam int unsigned N     = WIDTH / RADIX_BITS;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [PW-1:0]    mcand_sh;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    res_q;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;
    logic             neg;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             zero_c;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    prod;

    logic             accept_c;
    logic             step_c;
    logic             last_c;

    // Operand magnitudes; -2^(WIDTH-1) maps onto itself as an unsigned value
    always_comb begin
        sign1  = bus.mode[0] & bus.op1[WIDTH-1];
        sign2  = bus.mode[1] & bus.op2[WIDTH-1];
        mag1   = sign1 ? WIDTH'(-bus.op1) : bus.op1;
        mag2   = sign2 ? WIDTH'(-bus.op2) : bus.op2;
        zero_c = (bus.op1 == '0) || (bus.op2 == '0);
    end

    // Partial product of the pre-shifted multiplicand and the low multiplier digit
    always_comb begin
        pp = '0;
        for (int j = 0; j < int'(RADIX_BITS); j++) begin
            if (mplier[j]) begin
                pp = pp + (mcand_sh << j);
            end
        end
        acc_next = acc + pp;
        prod     = neg ? PW'(-acc_next) : acc_next;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_next = zero_c ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (count == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // abort and a completed handshake both end in IDLE
                if (bus.abort || bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        if (state == IDLE) begin
            accept_c = in_ready_q & bus.in_valid;
        end
        if (state == CALC) begin
            step_c = ~bus.abort;
            last_c = ~bus.abort & (count == CNT_W'(1));
        end
    end

    // Datapath and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_sh    <= '0;
            acc         <= '0;
            res_q       <= '0;
            mplier      <= '0;
            count       <= '0;
            neg         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_next == IDLE);
            out_valid_q <= (state_next == DONE);
            busy_q      <= (state_next != IDLE);
            if (accept_c) begin
                mcand_sh <= PW'(mag1);
                mplier   <= mag2;
                neg      <= sign1 ^ sign2;
                acc      <= '0;
                count    <= CNT_W'(N);
                if (zero_c) begin
                    res_q <= '0;
                end
            end else if (step_c) begin
                acc      <= acc_next;
                mcand_sh <= mcand_sh << RADIX_BITS;
                mplier   <= mplier >> RADIX_BITS;
                count    <= count - CNT_W'(1);
                // sign is applied once, on the final accumulation step
                if (last_c) begin
                    res_q <= prod;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter (WIDTH=32, RADIX_BITS=2, N=16).
// Stimulus pushes hand-computed products; a monitor pops them on each
// output handshake.
module tb_mul_iter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned PW    = 64;

    typedef struct {
        logic [PW-1:0] res;
        string         name;
    } exp_t;

    logic clk;
    logic rst;

    mul_iter_if #(.WIDTH(WIDTH)) bus ();

    mul_iter #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_res(input logic [PW-1:0] r, input string name);
        exp_t e;
        e.res  = r;
        e.name = name;
        sb.push_back(e);
    endtask

    // Returns just after the acceptance edge; operand lines are then scrambled
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        bus.op1      = a;
        bus.op2      = b;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op1      = $urandom;
        bus.op2      = $urandom;
        bus.mode     = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_out(input int lat_exp, input string name);
        int lat;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(lat_exp));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_in_ready"},  64'(bus.in_ready),  64'd0);
        chk({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({name, "_res"},       bus.res,            64'd0);
        chk({name, "_busy"},      64'(bus.busy),      64'd0);
    endtask

    // Monitor: every delivered product must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got res=%h with nothing pending", bus.res);
            end else begin
                mon_e = sb.pop_front();
                if (bus.res !== mon_e.res) begin
                    errors++;
                    $display("FAIL %s: got res=%h expected %h", mon_e.name, bus.res, mon_e.res);
                end
            end
        end
    end

    initial begin
        bit stale;
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.mode      = 2'b00;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unsigned maximum
        expect_res(64'hFFFFFFFE00000001, "unsigned_max");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00);
        wait_out(17, "unsigned_max");

        // Signed boundaries
        expect_res(64'h4000000000000000, "signed_min_sq");
        issue(32'h80000000, 32'h80000000, 2'b11);
        wait_out(17, "signed_min_sq");

        expect_res(64'hFFFFFFFF80000000, "signed_min_x1");
        issue(32'h80000000, 32'h00000001, 2'b11);
        wait_out(17, "signed_min_x1");

        expect_res(64'h0000000000000001, "signed_m1_sq");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11);
        wait_out(17, "signed_m1_sq");

        // Mixed sign, both orientations
        expect_res(64'hFFFFFFFF00000001, "mixed_su");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01);
        wait_out(17, "mixed_su");

        expect_res(64'hFFFFFFFF00000001, "mixed_us");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);
        wait_out(17, "mixed_us");

        // Signed mode on non-negative operands
        expect_res(64'd42, "signed_nonneg");
        issue(32'd7, 32'd6, 2'b11);
        wait_out(17, "signed_nonneg");

        // Zero early-out
        expect_res(64'd0, "zero_op1");
        issue(32'h00000000, 32'h12345678, 2'b11);
        wait_out(1, "zero_op1");

        expect_res(64'd0, "zero_op2");
        issue(32'h12345678, 32'h00000000, 2'b00);
        wait_out(1, "zero_op2");

        // Backpressure
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        expect_res(64'd15, "bp_result");
        issue(32'd3, 32'd5, 2'b00);
        wait_out(17, "bp");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_hold_res",      bus.res,             64'd15);
            chk("bp_hold_valid",    64'(bus.out_valid),  64'd1);
            chk("bp_hold_in_ready", 64'(bus.in_ready),   64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("bp_after_in_ready",  64'(bus.in_ready),  64'd1);
        chk("bp_after_out_valid", 64'(bus.out_valid), 64'd0);

        expect_res(64'd42, "bp_next");
        issue(32'd7, 32'd6, 2'b00);
        wait_out(17, "bp_next");

        // Abort sampled at edge T+5
        issue(32'd9, 32'd9, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_busy",      64'(bus.busy),      64'd0);

        expect_res(64'd6, "post_abort");
        issue(32'd2, 32'd3, 2'b00);
        wait_out(17, "post_abort");

        // Reset mid-operation at edge T+8
        issue(32'd5, 32'd5, 2'b00);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        chk("no_stale_output", 64'(stale), 64'd0);

        expect_res(64'h00000001FFFFFFFE, "post_reset");
        issue(32'hFFFFFFFF, 32'h00000002, 2'b00);
        wait_out(17, "post_reset");

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
